// File: rtl/ibex_alu_pext_simd_adder_if.sv
// Request/response bundle between the Zpn decoder, the SIMD adder and its consumer.
interface ibex_alu_pext_simd_adder_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        width32_i;
  logic        width8_i;
  logic        signed_ops_i;
  logic [1:0]  alu_sub_i;
  logic        crossed_i;
  logic        saturate_i;
  logic        halving_i;
  logic        rounding_i;
  logic        kill_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        ov_o;
  logic        vxsat_we_i;
  logic        vxsat_wdata_i;
  logic        vxsat_o;

  modport master (
    output valid_i, operand_a_i, operand_b_i, width32_i, width8_i, signed_ops_i,
           alu_sub_i, crossed_i, saturate_i, halving_i, rounding_i, kill_i,
           ready_i, vxsat_we_i, vxsat_wdata_i,
    input  ready_o, valid_o, result_o, ov_o, vxsat_o
  );

  modport slave (
    input  valid_i, operand_a_i, operand_b_i, width32_i, width8_i, signed_ops_i,
           alu_sub_i, crossed_i, saturate_i, halving_i, rounding_i, kill_i,
           ready_i, vxsat_we_i, vxsat_wdata_i,
    output ready_o, valid_o, result_o, ov_o, vxsat_o
  );
endinterface

// File: rtl/ibex_alu_pext_simd_adder.sv
// Two-stage P-extension SIMD add/sub: stage 1 forms exact W+1-bit lane sums,
// stage 2 applies wrap / saturate / halving and feeds the sticky vxsat flag.
module ibex_alu_pext_simd_add_lane #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sgn,
  input  logic         sub,
  output logic [W:0]   r
);
  logic [W:0] ea, eb;
  assign ea = {sgn & a[W-1], a};
  assign eb = {sgn & b[W-1], b};
  assign r  = sub ? ea - eb : ea + eb;
endmodule

module ibex_alu_pext_simd_fin_lane #(
  parameter int W = 8
) (
  input  logic [W:0]   r,
  input  logic         sgn,
  input  logic         sub,
  input  logic         sat,
  input  logic         halv,
  input  logic         rnd,
  output logic [W-1:0] res,
  output logic         ov
);
  logic [W-1:0] half;
  logic         oflow;

  // (r + rnd) >> 1: the rounding bit only carries out of bit 0 when r[0] is set
  assign half = r[W:1] + {{(W-1){1'b0}}, r[0] & rnd};
  // unsigned: r[W] is carry-out for add, borrow (negative) for sub
  assign oflow = sgn ? (r[W] != r[W-1]) : r[W];

  always_comb begin
    res = r[W-1:0];
    ov  = 1'b0;
    if (halv) begin
      res = half;
    end else if (sat && oflow) begin
      ov = 1'b1;
      if (sgn) res = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else     res = sub ? '0 : '1;
    end
  end
endmodule

module ibex_alu_pext_simd_adder #(
  parameter logic VXSAT_RESET = 1'b0
) (
  input logic                       clk_i,
  input logic                       rst_i,
  ibex_alu_pext_simd_adder_if.slave bus
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic       w32;
    logic       w8;
    logic       sgn;
    logic       sat;
    logic       halv;
    logic       rnd;
    logic [1:0] sub;
  } ctrl_t;

  logic s1_valid, s2_valid, s1_adv, s2_adv, accept;
  ctrl_t ctrl_d, s1_ctrl;
  logic [31:0] b_cross;
  logic [NUM_LANES-1:0][8:0]    r8_d, s1_r8;
  logic [NUM_LANES/2-1:0][16:0] r16_d, s1_r16;
  logic [32:0]                  r32_d, s1_r32;
  logic [NUM_LANES-1:0][7:0]    res8;
  logic [NUM_LANES-1:0]         ov8;
  logic [NUM_LANES/2-1:0][15:0] res16;
  logic [NUM_LANES/2-1:0]       ov16;
  logic [31:0] res32, res_d, s2_res;
  logic ov32, ov_d, s2_ov, vxsat;

  assign s2_adv = !s2_valid || bus.ready_i;
  assign s1_adv = !s1_valid || s2_adv;
  assign accept = bus.valid_i && s1_adv;

  assign ctrl_d = '{w32: bus.width32_i, w8: bus.width8_i, sgn: bus.signed_ops_i,
                    sat: bus.saturate_i, halv: bus.halving_i, rnd: bus.rounding_i,
                    sub: bus.alu_sub_i};
  // crossing only reaches the 16-bit lanes; 8/32-bit lanes use operand_b directly
  assign b_cross = bus.crossed_i ? {bus.operand_b_i[15:0], bus.operand_b_i[31:16]}
                                 : bus.operand_b_i;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_l8
    ibex_alu_pext_simd_add_lane #(.W(8)) u_add (
      .a(bus.operand_a_i[8*i+:8]), .b(bus.operand_b_i[8*i+:8]),
      .sgn(bus.signed_ops_i), .sub(bus.alu_sub_i[i/2]), .r(r8_d[i]));
    ibex_alu_pext_simd_fin_lane #(.W(8)) u_fin (
      .r(s1_r8[i]), .sgn(s1_ctrl.sgn), .sub(s1_ctrl.sub[i/2]), .sat(s1_ctrl.sat),
      .halv(s1_ctrl.halv), .rnd(s1_ctrl.rnd), .res(res8[i]), .ov(ov8[i]));
  end

  for (genvar i = 0; i < NUM_LANES/2; i++) begin : g_l16
    ibex_alu_pext_simd_add_lane #(.W(16)) u_add (
      .a(bus.operand_a_i[16*i+:16]), .b(b_cross[16*i+:16]),
      .sgn(bus.signed_ops_i), .sub(bus.alu_sub_i[i]), .r(r16_d[i]));
    ibex_alu_pext_simd_fin_lane #(.W(16)) u_fin (
      .r(s1_r16[i]), .sgn(s1_ctrl.sgn), .sub(s1_ctrl.sub[i]), .sat(s1_ctrl.sat),
      .halv(s1_ctrl.halv), .rnd(s1_ctrl.rnd), .res(res16[i]), .ov(ov16[i]));
  end

  ibex_alu_pext_simd_add_lane #(.W(32)) u_add32 (
    .a(bus.operand_a_i), .b(bus.operand_b_i), .sgn(bus.signed_ops_i),
    .sub(bus.alu_sub_i[0]), .r(r32_d));
  ibex_alu_pext_simd_fin_lane #(.W(32)) u_fin32 (
    .r(s1_r32), .sgn(s1_ctrl.sgn), .sub(s1_ctrl.sub[0]), .sat(s1_ctrl.sat),
    .halv(s1_ctrl.halv), .rnd(s1_ctrl.rnd), .res(res32), .ov(ov32));

  always_comb begin
    res_d = res16;
    ov_d  = |ov16;
    if (s1_ctrl.w32) begin
      res_d = res32;
      ov_d  = ov32;
    end else if (s1_ctrl.w8) begin
      res_d = res8;
      ov_d  = |ov8;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.kill_i) s1_valid <= 1'b0;
    else if (s1_adv)         s1_valid <= bus.valid_i;
    if (accept) begin
      s1_ctrl <= ctrl_d;
      s1_r8   <= r8_d;
      s1_r16  <= r16_d;
      s1_r32  <= r32_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_ov    <= 1'b0;
    end else begin
      if (bus.kill_i)  s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        s2_res <= res_d;
        s2_ov  <= ov_d;
      end
    end
  end

  // CSR write beats a same-cycle overflow; overflow counts only on output handshake
  always_ff @(posedge clk_i) begin
    if (rst_i)                              vxsat <= VXSAT_RESET;
    else if (bus.vxsat_we_i)                vxsat <= bus.vxsat_wdata_i;
    else if (s2_valid && bus.ready_i && s2_ov) vxsat <= 1'b1;
  end

  assign bus.ready_o  = s1_adv;
  assign bus.valid_o  = s2_valid;
  assign bus.result_o = s2_res;
  assign bus.ov_o     = s2_ov;
  assign bus.vxsat_o  = vxsat;
endmodule

// File: tb/tb_ibex_alu_pext_simd_adder.sv
// Bench for the P-extension SIMD adder: directed vector table, handshake corner
// sequences and randomized traffic, all scored against an integer-arithmetic model.
module tb_ibex_alu_pext_simd_adder;
  localparam logic VXR = 1'b0;

  typedef struct {
    logic [31:0] a, b;
    logic w32, w8, sgn;
    logic [1:0] sub;
    logic cr, sat, hv, rn;
  } op_t;
  typedef struct { op_t op; logic [31:0] res; logic ov; } vec_t;
  typedef struct { logic [31:0] res; logic ov; int t; } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_alu_pext_simd_adder_if bus();
  ibex_alu_pext_simd_adder #(.VXSAT_RESET(VXR)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0, errors = 0, tcnt = 0;
  item_t q[$];
  logic exp_vx;
  op_t cur, nop;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tick=%0d actual=%h required=%h", name, tcnt, act, exp);
    end
  endtask

  // Lane-by-lane integer arithmetic straight from the lane rules.
  function automatic item_t model(op_t o);
    item_t it;
    int w, n;
    logic [63:0] mask;
    logic [31:0] bb;
    longint x, y, r, lo, hi, v;
    logic sb;
    w = o.w32 ? 32 : (o.w8 ? 8 : 16);
    n = 32 / w;
    mask = (64'd1 << w) - 64'd1;
    bb = (w == 16 && o.cr) ? {o.b[15:0], o.b[31:16]} : o.b;
    it.res = '0; it.ov = 1'b0; it.t = 0;
    for (int i = 0; i < n; i++) begin
      x = longint'(({32'd0, o.a} >> (i*w)) & mask);
      y = longint'(({32'd0, bb} >> (i*w)) & mask);
      if (o.sgn) begin
        if (x >= (longint'(1) <<< (w-1))) x -= (longint'(1) <<< w);
        if (y >= (longint'(1) <<< (w-1))) y -= (longint'(1) <<< w);
        lo = -(longint'(1) <<< (w-1));
        hi = (longint'(1) <<< (w-1)) - 1;
      end else begin
        lo = 0;
        hi = (longint'(1) <<< w) - 1;
      end
      sb = (w == 32) ? o.sub[0] : ((w == 8) ? o.sub[i/2] : o.sub[i]);
      r = sb ? x - y : x + y;
      if (o.hv) v = (r + longint'(o.rn)) >>> 1;
      else if (o.sat && (r < lo || r > hi)) begin
        v = (r < lo) ? lo : hi;
        it.ov = 1'b1;
      end else v = r;
      it.res = it.res | 32'((64'(v) & mask) << (i*w));
    end
    return it;
  endfunction

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic w32, logic w8,
                              logic sgn, logic [1:0] sub, logic cr, logic sat,
                              logic hv, logic rn, logic [31:0] res, logic ov);
    vec_t v;
    v.op = '{a: a, b: b, w32: w32, w8: w8, sgn: sgn, sub: sub, cr: cr, sat: sat, hv: hv, rn: rn};
    v.res = res; v.ov = ov;
    return v;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    logic [31:0] edge_vals [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                   32'h0000_0000, 32'h7F80_7F80, 32'h8080_8080};
    o.a   = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
    o.b   = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
    o.w32 = ($urandom_range(0, 2) == 0);
    o.w8  = 1'($urandom_range(0, 1));
    o.sgn = 1'($urandom_range(0, 1));
    o.sub = 2'($urandom_range(0, 3));
    o.cr  = 1'($urandom_range(0, 1));
    o.sat = 1'($urandom_range(0, 1));
    o.hv  = ($urandom_range(0, 3) == 0);
    o.rn  = 1'($urandom_range(0, 1));
    return o;
  endfunction

  task automatic drive(op_t o, logic v);
    cur = o;
    bus.valid_i = v;
    bus.operand_a_i = o.a;    bus.operand_b_i = o.b;
    bus.width32_i = o.w32;    bus.width8_i = o.w8;
    bus.signed_ops_i = o.sgn; bus.alu_sub_i = o.sub;
    bus.crossed_i = o.cr;     bus.saturate_i = o.sat;
    bus.halving_i = o.hv;     bus.rounding_i = o.rn;
  endtask

  // One cycle: check outputs against the scoreboard, then advance the scoreboard
  // by what the coming clock edge will do.
  task automatic tick();
    int n;
    logic vis, hs, hov;
    item_t it;
    #1;
    n = q.size();
    vis = (n > 0) && ((tcnt - q[0].t) >= 2);
    chk("valid_o", bus.valid_o, vis);
    chk("ready_o", bus.ready_o, (n < 2) || bus.ready_i);
    chk("vxsat_o", bus.vxsat_o, exp_vx);
    if (vis) begin
      chk("result_o", bus.result_o, q[0].res);
      chk("ov_o", bus.ov_o, q[0].ov);
    end
    if (rst) begin
      q.delete();
      exp_vx = VXR;
    end else begin
      hs  = vis && bus.ready_i;
      hov = hs && q[0].ov;
      if (hs) void'(q.pop_front());
      if (bus.vxsat_we_i) exp_vx = bus.vxsat_wdata_i;
      else if (hov)       exp_vx = 1'b1;
      if (bus.kill_i) q.delete();
      else if (bus.valid_i && ((n < 2) || bus.ready_i)) begin
        it = model(cur);
        it.t = tcnt;
        q.push_back(it);
      end
    end
    tcnt++;
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[15];
    nop = '{a: '0, b: '0, w32: 1'b0, w8: 1'b0, sgn: 1'b0, sub: 2'b00, cr: 1'b0, sat: 1'b0, hv: 1'b0, rn: 1'b0};
    tbl[0]  = mk(32'h7FFF_0001, 32'h0001_0001, 0, 0, 1, 2'b00, 0, 1, 0, 0, 32'h7FFF_0002, 1); // KADD16
    tbl[1]  = mk(32'h0010_FF05, 32'h2001_0106, 0, 1, 0, 2'b11, 0, 1, 0, 0, 32'h000F_FE00, 1); // UKSUB8
    tbl[2]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 1, 0, 1, 2'b00, 0, 0, 1, 0, 32'h4000_0000, 0); // RADDW
    tbl[3]  = mk(32'h0000_0003, 32'h0000_0004, 1, 0, 1, 2'b00, 0, 0, 1, 1, 32'h0000_0004, 0); // AVE
    tbl[4]  = mk(32'h1000_2000, 32'h0003_0005, 0, 0, 1, 2'b01, 1, 1, 0, 0, 32'h1005_1FFD, 0); // KCRAS16
    tbl[5]  = mk(32'hFF7F_0180, 32'h0101_0180, 0, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0080_0200, 0); // ADD8 wrap
    tbl[6]  = mk(32'hFF7F_0180, 32'h0101_0180, 0, 1, 1, 2'b00, 0, 1, 0, 0, 32'h007F_0280, 1); // KADD8
    tbl[7]  = mk(32'h8000_0001, 32'h0001_0002, 0, 0, 1, 2'b11, 0, 1, 0, 0, 32'h8000_FFFF, 1); // KSUB16
    tbl[8]  = mk(32'hFFFF_0001, 32'h0002_0001, 0, 0, 0, 2'b00, 0, 1, 0, 0, 32'hFFFF_0002, 1); // UKADD16
    tbl[9]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 0, 2'b00, 0, 1, 0, 0, 32'hFFFF_FFFF, 1); // UKADDW
    tbl[10] = mk(32'h8000_0000, 32'h0000_0001, 1, 0, 1, 2'b01, 0, 1, 0, 0, 32'h8000_0000, 1); // KSUBW
    tbl[11] = mk(32'h0000_0010, 32'h0000_0102, 0, 1, 0, 2'b11, 0, 0, 1, 0, 32'h0000_FF07, 0); // URSUB8
    tbl[12] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1, 0, 1, 2'b00, 0, 0, 0, 0, 32'h8000_0000, 0); // ADDW wrap
    tbl[13] = mk(32'h0102_0304, 32'h0100_0000, 0, 1, 0, 2'b00, 1, 0, 0, 0, 32'h0202_0304, 0); // cross ignored in 8b
    tbl[14] = mk(32'h8000_0003, 32'h8000_0000, 0, 0, 1, 2'b00, 0, 0, 1, 1, 32'h8000_0002, 0); // RADD16 rounded

    drive(nop, 1'b0);
    bus.ready_i = 1'b1; bus.kill_i = 1'b0;
    bus.vxsat_we_i = 1'b0; bus.vxsat_wdata_i = 1'b0;
    exp_vx = VXR;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_result", bus.result_o, 32'd0);
    chk("reset_ov", bus.ov_o, 32'd0);
    tick();

    // directed vectors, one at a time: valid_o must appear exactly two cycles after accept
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].op, 1'b1); tick();
      drive(nop, 1'b0);       tick();
      #1;
      chk($sformatf("vec%0d_result", i), bus.result_o, tbl[i].res);
      chk($sformatf("vec%0d_ov", i), bus.ov_o, tbl[i].ov);
      tick();
    end

    // backpressure: third op must be refused, stalled result held, then in-order drain
    bus.ready_i = 1'b0;
    drive(tbl[5].op, 1'b1); tick();
    drive(tbl[6].op, 1'b1); tick();
    drive(tbl[7].op, 1'b1); tick();
    drive(nop, 1'b0); repeat (3) tick();
    bus.ready_i = 1'b1; repeat (4) tick();

    // CSR write of 0 colliding with a saturating output handshake
    bus.vxsat_we_i = 1'b1; bus.vxsat_wdata_i = 1'b0; tick();
    bus.vxsat_we_i = 1'b0;
    drive(tbl[0].op, 1'b1); tick();
    drive(nop, 1'b0);       tick();
    bus.vxsat_we_i = 1'b1; bus.vxsat_wdata_i = 1'b0; tick();
    bus.vxsat_we_i = 1'b0; tick();
    #1 chk("vxsat_collision", bus.vxsat_o, 32'd0);

    // kill with two ops in flight under backpressure
    bus.ready_i = 1'b0;
    drive(tbl[0].op, 1'b1); tick();
    drive(tbl[6].op, 1'b1); tick();
    drive(tbl[1].op, 1'b1); bus.kill_i = 1'b1; tick();
    bus.kill_i = 1'b0; drive(nop, 1'b0); bus.ready_i = 1'b1; tick();
    #1 chk("kill_valid", bus.valid_o, 32'd0);
    repeat (2) tick();

    // kill drops an input offered in the same cycle while ready
    drive(tbl[0].op, 1'b1); tick();
    drive(tbl[6].op, 1'b1); bus.kill_i = 1'b1; tick();
    bus.kill_i = 1'b0; drive(nop, 1'b0); repeat (3) tick();
    #1 chk("kill_vxsat", bus.vxsat_o, 32'd0);

    // reset while a saturating result is being delivered
    drive(tbl[0].op, 1'b1); tick();
    drive(tbl[6].op, 1'b1); tick();
    drive(nop, 1'b0); rst = 1'b1; tick();
    rst = 1'b0;
    #1;
    chk("midrst_result", bus.result_o, 32'd0);
    chk("midrst_ov", bus.ov_o, 32'd0);
    chk("midrst_vxsat", bus.vxsat_o, 32'(VXR));
    tick();

    // randomized traffic with backpressure, kills and CSR writes
    for (int i = 0; i < 600; i++) begin
      drive(rand_op(), ($urandom_range(0, 3) != 0));
      bus.ready_i = ($urandom_range(0, 3) != 0);
      bus.kill_i = ($urandom_range(0, 40) == 0);
      bus.vxsat_we_i = ($urandom_range(0, 20) == 0);
      bus.vxsat_wdata_i = 1'($urandom_range(0, 1));
      tick();
    end
    drive(nop, 1'b0);
    bus.ready_i = 1'b1; bus.kill_i = 1'b0; bus.vxsat_we_i = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
